// File: rtl/fir_mac_sequencer_if.sv
// Stream bundle between the FIR sequencer and its neighbours:
// ss_* carries input samples in, sm_* carries filtered results out.
interface fir_mac_sequencer_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tready;
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    modport master (
        output ss_tvalid, ss_tdata, sm_tready,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport slave (
        input  ss_tvalid, ss_tdata, sm_tready,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR control: keeps sample history as a circular buffer in data RAM,
// walks tap/data RAMs into the MAC PE and streams one result per input.
module fir_mac_sequencer #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic [5:0]             tap_num,
    input  logic [31:0]            data_length,
    fir_mac_sequencer_if.slave     axis,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [pDATA_WIDTH-1:0] pe_mul_a,
    output logic [pDATA_WIDTH-1:0] pe_mul_b,
    output logic                   pe_cal,
    output logic                   pe_acc_on,
    output logic                   pe_last,
    input  logic [pDATA_WIDTH-1:0] pe_result
);
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, CALC, OUT, DONE} state_t;

    state_t                 state, state_nx;
    logic [5:0]             tap_n, cnt_k, wr_ptr, rd_idx;
    logic [31:0]            len, n_out;
    logic [pDATA_WIDTH-1:0] result;
    logic                   legal_start, last_out;

    assign legal_start = ap_start && (tap_num != 6'd0) && (tap_num <= 6'(Tape_Num));
    assign last_out    = (n_out == len - 32'd1);
    // newest sample sits at wr_ptr; tap k pairs with the sample k slots older
    assign rd_idx      = (wr_ptr >= cnt_k) ? wr_ptr - cnt_k : wr_ptr + tap_n - cnt_k;
    assign axis.sm_tdata = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        ap_idle        = 1'b0;
        ap_done        = 1'b0;
        axis.ss_tready = 1'b0;
        axis.sm_tvalid = 1'b0;
        axis.sm_tlast  = 1'b0;
        data_EN        = 1'b0;
        data_WE        = 4'h0;
        data_A         = '0;
        data_Di        = '0;
        tap_EN         = 1'b0;
        tap_A          = '0;
        pe_mul_a       = '0;
        pe_mul_b       = '0;
        pe_cal         = 1'b0;
        pe_acc_on      = 1'b0;
        pe_last        = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (legal_start) state_nx = CLEAR;
            end
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = pADDR_WIDTH'({cnt_k, 2'b00});
                if (cnt_k == tap_n - 6'd1) state_nx = (len == 32'd0) ? DONE : WAIT_IN;
            end
            WAIT_IN: begin
                axis.ss_tready = 1'b1;
                if (axis.ss_tvalid) begin
                    data_EN  = 1'b1;
                    data_WE  = 4'hF;
                    data_A   = pADDR_WIDTH'({wr_ptr, 2'b00});
                    data_Di  = axis.ss_tdata;
                    state_nx = CALC;
                end
            end
            CALC: begin
                // issue read k on cnt_k==k, consume its data on cnt_k==k+1
                if (cnt_k < tap_n) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = pADDR_WIDTH'({cnt_k, 2'b00});
                    data_A  = pADDR_WIDTH'({rd_idx, 2'b00});
                end
                if (cnt_k != 6'd0) begin
                    pe_mul_a  = data_Do;
                    pe_mul_b  = tap_Do;
                    pe_cal    = 1'b1;
                    pe_acc_on = (cnt_k != 6'd1);
                    pe_last   = (cnt_k == tap_n);
                end
                if (cnt_k == tap_n) state_nx = OUT;
            end
            OUT: begin
                axis.sm_tvalid = 1'b1;
                axis.sm_tlast  = last_out;
                if (axis.sm_tready) state_nx = last_out ? DONE : WAIT_IN;
            end
            DONE: begin
                ap_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_n  <= '0;
            len    <= '0;
            cnt_k  <= '0;
            wr_ptr <= '0;
            n_out  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (legal_start) begin
                    tap_n  <= tap_num;
                    len    <= data_length;
                    cnt_k  <= '0;
                    wr_ptr <= '0;
                    n_out  <= '0;
                end
                CLEAR: cnt_k <= (cnt_k == tap_n - 6'd1) ? 6'd0 : cnt_k + 6'd1;
                CALC: begin
                    cnt_k <= (cnt_k == tap_n) ? 6'd0 : cnt_k + 6'd1;
                    if (cnt_k == tap_n) result <= pe_result;
                end
                OUT: if (axis.sm_tready) begin
                    n_out <= n_out + 32'd1;
                    if (!last_out) wr_ptr <= (wr_ptr == tap_n - 6'd1) ? 6'd0 : wr_ptr + 6'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: behavioural RAMs and PE around the DUT,
// scoreboard of expected {result,last} checked at each output handshake.
module tb_fir_mac_sequencer;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_idle, ap_done;
    logic [5:0]    tap_num = 6'd0;
    logic [31:0]   data_length = 32'd0;
    logic          data_EN, tap_EN;
    logic [3:0]    data_WE;
    logic [AW-1:0] data_A, tap_A;
    logic [DW-1:0] data_Di, data_Do, tap_Do;
    logic [DW-1:0] pe_mul_a, pe_mul_b, pe_result, acc;
    logic          pe_cal, pe_acc_on, pe_last;
    logic          fill = 1'b0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.pDATA_WIDTH(DW)) bus ();

    fir_mac_sequencer #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .tap_num(tap_num), .data_length(data_length), .axis(bus.slave),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do),
        .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
        .pe_mul_a(pe_mul_a), .pe_mul_b(pe_mul_b), .pe_cal(pe_cal), .pe_acc_on(pe_acc_on),
        .pe_last(pe_last), .pe_result(pe_result)
    );

    logic [DW-1:0] dmem [16];
    logic [DW-1:0] tmem [16];
    logic [DW-1:0] hist [16];
    logic [32:0]   sb [$];
    int            checks = 0, errors = 0, done_cnt = 0, cur_tn = 1;

    // data RAM starts full of garbage so only CLEAR can produce zero history
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'hBAD0_0000 + i;
        end else if (data_EN) begin
            if (data_WE == 4'hF) dmem[data_A[5:2]] <= data_Di;
            data_Do <= dmem[data_A[5:2]];
        end
        if (tap_EN) tap_Do <= tmem[tap_A[5:2]];
    end

    assign pe_result = (pe_acc_on ? acc : 32'd0) + pe_mul_a * pe_mul_b;
    always @(posedge clk) if (pe_cal) acc <= pe_result;

    always @(negedge clk) begin
        if (ap_done) done_cnt++;
        if (rst_n && bus.sm_tvalid && bus.sm_tready) begin
            logic [32:0] exp_v;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0d last=%b, nothing expected", bus.sm_tdata, bus.sm_tlast);
            end else begin
                exp_v = sb.pop_front();
                if ({bus.sm_tdata, bus.sm_tlast} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_out: got %0d last=%b, expected %0d last=%b",
                             bus.sm_tdata, bus.sm_tlast, exp_v[32:1], exp_v[0]);
                end
            end
        end
    end

    task automatic push_model(input logic [31:0] x, input logic last);
        logic [31:0] y = 32'd0;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        for (int k = 0; k < cur_tn; k++) y += tmem[k] * hist[k];
        sb.push_back({y, last});
    endtask

    task automatic start_run(input int tn, input int len);
        cur_tn = tn;
        for (int i = 0; i < 16; i++) hist[i] = 32'd0;
        tap_num = 6'(tn);
        data_length = 32'(len);
        @(posedge clk); #1 ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x);
        bit got = 0;
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = x;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.ss_tready) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL send_timeout: ss_tready=%b, required 1", bus.ss_tready); end
        @(posedge clk); #1 bus.ss_tvalid = 1'b0;
    endtask

    task automatic finish_run(input string name);
        bit got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (ap_done) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_done: ap_done=0, required 1", name); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL %s_left: %0d outputs missing, required 0", name, sb.size()); end
        @(negedge clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0)
            begin errors++; $display("FAIL %s_idle: idle=%b done=%b, required 1/0", name, ap_idle, ap_done); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || bus.ss_tready !== 1'b0 || bus.sm_tvalid !== 1'b0 ||
            bus.sm_tdata !== 32'd0 || data_EN !== 1'b0 || tap_EN !== 1'b0 || pe_cal !== 1'b0)
            begin errors++; $display("FAIL reset_vals: idle=%b done=%b ssr=%b smv=%b smd=%0d den=%b ten=%b cal=%b, required 1,0,0,0,0,0,0,0",
                ap_idle, ap_done, bus.ss_tready, bus.sm_tvalid, bus.sm_tdata, data_EN, tap_EN, pe_cal); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ap_idle !== 1'b1 || bus.ss_tready !== 1'b0)
            begin errors++; $display("FAIL reset_release: idle=%b ssr=%b, required 1/0", ap_idle, bus.ss_tready); end
    endtask

    task automatic test_tap1();
        int d0 = done_cnt;
        tmem[0] = 32'd3;
        start_run(1, 3);
        sb.push_back({32'd3, 1'b0});  send(32'd1);
        sb.push_back({32'd6, 1'b0});  send(32'd2);
        sb.push_back({32'd15, 1'b1}); send(32'd5);
        finish_run("tap1");
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL tap1_done_pulses: %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_tap4_wrap();
        int expv [6] = '{1, 3, 6, 10, 10, 10};
        for (int k = 0; k < 4; k++) tmem[k] = 32'(k + 1);
        start_run(4, 6);
        for (int i = 0; i < 6; i++) begin
            sb.push_back({32'(expv[i]), i == 5});
            send(32'd1);
        end
        finish_run("tap4");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            start_run(4, 5);
            for (int i = 0; i < 5; i++) begin
                push_model(32'(9 - i), i == 4);
                send(32'(9 - i));
            end
            finish_run(r == 0 ? "b2b_first" : "b2b_second");
        end
    endtask

    task automatic test_latency();
        int lat = 0, ncal = 0, nacc0 = 0;
        bit got = 0, first_ok = 0;
        for (int k = 0; k < 11; k++) tmem[k] = 32'(k + 1);
        start_run(11, 1);
        push_model(32'd7, 1'b1);
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = 32'd7;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.ss_tready) begin got = 1; break; end
        end
        @(posedge clk); #1 bus.ss_tvalid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (pe_cal) begin
                ncal++;
                if (!pe_acc_on) nacc0++;
                if (ncal == 1) first_ok = !pe_acc_on;
            end
            if (bus.sm_tvalid) begin lat = n; break; end
        end
        checks++;
        if (!got || lat != 13) begin errors++; $display("FAIL lat_cycles: %0d, required 13", lat); end
        checks++;
        if (ncal != 11) begin errors++; $display("FAIL lat_cal_count: %0d, required 11", ncal); end
        checks++;
        if (nacc0 != 1 || !first_ok) begin errors++; $display("FAIL lat_acc_on: low %0d times first_ok=%b, required 1/1", nacc0, first_ok); end
        finish_run("lat");
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        l;
        bit          got = 0;
        tmem[0] = 32'd2; tmem[1] = 32'd3;
        bus.sm_tready = 1'b0;
        start_run(2, 2);
        push_model(32'd4, 1'b0);
        send(32'd4);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.sm_tvalid) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL bp_valid: sm_tvalid=0, required 1"); end
        d = bus.sm_tdata;
        l = bus.sm_tlast;
        checks++;
        if (d !== 32'd8 || l !== 1'b0) begin errors++; $display("FAIL bp_value: %0d last=%b, required 8/0", d, l); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (bus.sm_tvalid !== 1'b1 || bus.sm_tdata !== d || bus.sm_tlast !== l || bus.ss_tready !== 1'b0)
                begin errors++; $display("FAIL bp_hold: v=%b d=%0d l=%b ssr=%b, required 1/%0d/%b/0",
                    bus.sm_tvalid, bus.sm_tdata, bus.sm_tlast, bus.ss_tready, d, l); end
        end
        @(posedge clk); #1 bus.sm_tready = 1'b1;
        push_model(32'd5, 1'b1);
        send(32'd5);
        finish_run("bp");
    endtask

    task automatic test_bad_start();
        int bad [2] = '{0, 12};
        for (int b = 0; b < 2; b++) begin
            tap_num = 6'(bad[b]);
            data_length = 32'd3;
            @(posedge clk); #1 ap_start = 1'b1;
            @(posedge clk); #1 ap_start = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                checks++;
                if (ap_idle !== 1'b1 || data_EN !== 1'b0 || tap_EN !== 1'b0 || ap_done !== 1'b0)
                    begin errors++; $display("FAIL bad_start_%0d: idle=%b den=%b ten=%b done=%b, required 1/0/0/0",
                        bad[b], ap_idle, data_EN, tap_EN, ap_done); end
            end
        end
    endtask

    task automatic test_zero_len();
        int  wr = 0;
        bit  got = 0;
        start_run(4, 0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (data_EN && data_WE == 4'hF) begin
                checks++;
                if (data_A !== AW'(wr * 4) || data_Di !== 32'd0)
                    begin errors++; $display("FAIL zl_write: addr=%0d data=%0d, required %0d/0", data_A, data_Di, wr * 4); end
                wr++;
            end
            if (ap_done) begin got = 1; break; end
        end
        checks++;
        if (!got || wr != 4) begin errors++; $display("FAIL zl_count: writes=%0d done=%b, required 4/1", wr, got); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) tmem[k] = 32'(k + 1);
        start_run(4, 3);
        push_model(32'd3, 1'b0);
        send(32'd3);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || bus.ss_tready !== 1'b0 || bus.sm_tvalid !== 1'b0 ||
            bus.sm_tlast !== 1'b0 || bus.sm_tdata !== 32'd0 || data_EN !== 1'b0 || data_WE !== 4'h0 ||
            tap_EN !== 1'b0 || pe_cal !== 1'b0 || pe_acc_on !== 1'b0 || pe_last !== 1'b0 ||
            pe_mul_a !== 32'd0 || pe_mul_b !== 32'd0)
            begin errors++; $display("FAIL mid_reset_vals: idle=%b smv=%b smd=%0d den=%b ten=%b cal=%b, required 1,0,0,0,0,0",
                ap_idle, bus.sm_tvalid, bus.sm_tdata, data_EN, tap_EN, pe_cal); end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_run(4, 3);
        sb.push_back({32'd2, 1'b0});  send(32'd2);
        sb.push_back({32'd8, 1'b0});  send(32'd4);
        sb.push_back({32'd20, 1'b1}); send(32'd6);
        finish_run("mid_fresh");
    endtask

    initial begin
        bus.ss_tvalid = 1'b0;
        bus.ss_tdata  = '0;
        bus.sm_tready = 1'b1;
        for (int i = 0; i < 16; i++) tmem[i] = 32'd0;
        @(posedge clk); #1 fill = 1'b1;
        @(posedge clk); #1 fill = 1'b0;
        test_reset();
        test_tap4_wrap();
        test_tap1();
        test_back_to_back();
        test_latency();
        test_backpressure();
        test_bad_start();
        test_zero_len();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview: Control side of the FIR datapath. It accepts input samples on an AXI-Stream-style slave, maintains the sample history as a circular buffer in an external data RAM, and walks the tap and data RAMs to feed the multiply-accumulate PE (mul_a/mul_b/cal/acc_on/last). It captures each PE result and emits it on an AXI-Stream-style master, with ap_start/ap_idle/ap_done block control.

Parameters:
pADDR_WIDTH, 12, RAM byte-address width
pDATA_WIDTH, 32, sample/tap/result width
Tape_Num, 11, maximum tap count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  start pulse, sampled in IDLE only
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse at run end
tap_num  in  6  taps this run, legal 1..Tape_Num
data_length  in  32  samples this run
ss_tvalid / ss_tdata / ss_tready  in / in / out  1 / pDATA_WIDTH / 1  input stream
sm_tvalid / sm_tdata / sm_tlast / sm_tready  out / out / out / in  1 / pDATA_WIDTH / 1 / 1  output stream
data_EN / data_WE / data_A / data_Di / data_Do  out / out / out / out / in  1 / 4 / pADDR_WIDTH / pDATA_WIDTH / pDATA_WIDTH  data RAM, 1-cycle read latency
tap_EN / tap_A / tap_Do  out / out / in  1 / pADDR_WIDTH / pDATA_WIDTH  tap RAM read port, 1-cycle read latency
pe_mul_a / pe_mul_b / pe_cal / pe_acc_on / pe_last  out  pDATA_WIDTH / pDATA_WIDTH / 1 / 1 / 1  PE drive
pe_result  in  pDATA_WIDTH  PE output, valid when pe_last=1

Behaviour:
- Reset values: ap_idle=1, all other outputs 0. State=IDLE, wr_ptr=0, sample count=0. RAM contents are untouched.
- FSM states: IDLE, CLEAR, WAIT_IN, CALC, OUT, DONE.
- IDLE:
  - ap_start with 1<=tap_num<=Tape_Num latches tap_num and data_length, then goes to CLEAR. Otherwise ap_start is ignored.
  - ap_start in any other state is ignored.
- CLEAR:
  - Writes 0 to data addresses (i<<2) for i=0..tap_num-1, one per cycle, with data_EN=1 and data_WE=4'hF. Takes tap_num cycles.
  - Then goes to WAIT_IN, or to DONE if data_length==0.
- WAIT_IN:
  - ss_tready=1.
  - On ss_tvalid&ss_tready, in the same cycle: data_EN=1, data_WE=4'hF, data_A=wr_ptr<<2, data_Di=ss_tdata. Then goes to CALC.
  - ss_tlast is ignored. Termination is by data_length only.
- CALC, issue cycle k=0..tap_num-1:
  - tap_EN=data_EN=1, data_WE=0, tap_A=k<<2, data_A=((wr_ptr-k) mod tap_num)<<2.
  - Return cycle k+1: pe_mul_a=data_Do, pe_mul_b=tap_Do, pe_cal=1, pe_acc_on=(k!=0), pe_last=(k==tap_num-1).
  - In the pe_last cycle, pe_result is registered into sm_tdata.
  - CALC lasts tap_num+1 cycles, then goes to OUT. pe_cal, pe_acc_on and pe_last are 0 outside return cycles.
- Latency: input handshake at cycle t gives sm_tvalid=1 at cycle t+tap_num+2.
- OUT:
  - sm_tvalid=1. sm_tlast=1 iff this is sample number data_length.
  - sm_tdata and sm_tlast stay stable until sm_tready. ss_tready=0 throughout.
  - On handshake, the sample count increments.
  - If last, go to DONE. Otherwise wr_ptr=(wr_ptr==tap_num-1)?0:wr_ptr+1 and go to WAIT_IN.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- Arithmetic: the sequencer performs no arithmetic on data. Sums wrap mod 2^pDATA_WIDTH inside the PE. Computes y[n]=sum h[k]*x[n-k], with pre-run history zero.
- Simultaneous events: sm_tready high on the first OUT cycle completes the handshake in that cycle.
- Reset mid-operation: immediate return to IDLE with reset values. A partial output is never emitted, and a pending PE accumulation is discarded.

Test Plan:
- tap_num=1, tap[0]=3, data_length=3, inputs 1,2,5 -> outputs 3,6,15; sm_tlast only on 15; one ap_done pulse; ap_idle returns to 1.
- tap_num=4, taps 1,2,3,4, data_length=6, six inputs of 1 -> outputs 1,3,6,10,10,10. This exercises wr_ptr wrap and zeroed history.
- Two back-to-back runs with the same taps (second after ap_done) -> second run output identical to first, proving CLEAR wipes history.
- tap_num=11, sm_tready held 1 -> sm_tvalid rises exactly 13 cycles after the input handshake; pe_cal high exactly 11 cycles; pe_acc_on low only on the first of them.
- sm_tready low for 5 cycles during OUT -> sm_tdata/sm_tlast stable, ss_tready=0 throughout; completes when sm_tready rises.
- Illegal and abort cases, each checked separately:
  - ap_start with tap_num=0 -> ap_idle stays 1 and no RAM access.
  - tap_num=4, data_length=0 -> 4 clear writes then ap_done.
  - rst_n low mid-CALC -> all outputs at reset values; a fresh run then produces correct outputs.
